// File: rtl/mul_hilo_ctrl.sv
// Sequencer and HI/LO result stage for the multi-cycle signed Booth multiplier.
// Holds operands for LATENCY cycles, then captures the 2*DATA_WIDTH product into HI/LO.
module mul_hilo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_q,
  input  logic [DATA_WIDTH-1:0]   op_m,
  input  logic                    flush,
  input  logic                    wr_hi,
  input  logic                    wr_lo,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   mul_q,
  output logic [DATA_WIDTH-1:0]   mul_m,
  input  logic [2*DATA_WIDTH-1:0] mul_prod,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              load_ops;
  logic              capture;

  // Counter counts down from LATENCY-1; the edge that sees zero is the capture edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_ops   = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          load_ops   = 1'b1;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (cnt == '0) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Operands stay put after completion or flush so the multiplier inputs never glitch.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      mul_q <= '0;
      mul_m <= '0;
    end else if (load_ops) begin
      mul_q <= op_q;
      mul_m <= op_m;
    end
  end

  // A product capture overrides any direct write landing on the same edge.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= capture;
      if (capture) begin
        hi <= mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        lo <= mul_prod[DATA_WIDTH-1:0];
      end else begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
    end
  end

  assign busy = (state == ST_WAIT);

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: directed scenarios plus random traffic
// compared against a deadline-based reference model of HI/LO, busy and done.
module tb_mul_hilo_ctrl;

  localparam int W       = 32;
  localparam int LATENCY = 4;

  logic           clock;
  logic           clear_n;
  logic           start;
  logic [W-1:0]   op_q;
  logic [W-1:0]   op_m;
  logic           flush;
  logic           wr_hi;
  logic           wr_lo;
  logic [W-1:0]   wr_data;
  logic [W-1:0]   mul_q;
  logic [W-1:0]   mul_m;
  logic [2*W-1:0] mul_prod;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit             m_busy;
  int             m_due;
  int             edge_num;
  logic [W-1:0]   m_q;
  logic [W-1:0]   m_m;
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;
  bit             m_done;

  mul_hilo_ctrl #(.DATA_WIDTH(W), .LATENCY(LATENCY)) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .start    (start),
    .op_q     (op_q),
    .op_m     (op_m),
    .flush    (flush),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wr_data  (wr_data),
    .mul_q    (mul_q),
    .mul_m    (mul_m),
    .mul_prod (mul_prod),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    sa = $signed({{W{a[W-1]}}, a});
    sb = $signed({{W{b[W-1]}}, b});
    return sa * sb;
  endfunction

  // Stand-in for the combinational Booth multiplier
  assign mul_prod = ref_prod(mul_q, mul_m);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_num);
    end
  endtask

  task automatic modelReset();
    m_busy = 0;
    m_due  = 0;
    m_q    = '0;
    m_m    = '0;
    m_hi   = '0;
    m_lo   = '0;
    m_done = 0;
  endtask

  task automatic compareAll();
    checkOutput("busy",  64'(busy),  64'(m_busy));
    checkOutput("done",  64'(done),  64'(m_done));
    checkOutput("hi",    64'(hi),    64'(m_hi));
    checkOutput("lo",    64'(lo),    64'(m_lo));
    checkOutput("mul_q", 64'(mul_q), 64'(m_q));
    checkOutput("mul_m", 64'(mul_m), 64'(m_m));
  endtask

  // Compares current outputs, drives one cycle of inputs, advances the model at the edge.
  task automatic applyStimulus(input bit s, input bit f, input bit wh, input bit wl,
                               input logic [W-1:0] wd, input logic [W-1:0] oq,
                               input logic [W-1:0] om);
    bit cap;
    compareAll();
    start   = s;
    flush   = f;
    wr_hi   = wh;
    wr_lo   = wl;
    wr_data = wd;
    op_q    = oq;
    op_m    = om;
    @(posedge clock);
    edge_num++;
    cap = 0;
    if (m_busy) begin
      if (f) m_busy = 0;
      else if (edge_num == m_due) cap = 1;
    end else if (s && !f) begin
      m_q    = oq;
      m_m    = om;
      m_busy = 1;
      m_due  = edge_num + LATENCY;
    end
    if (cap) begin
      {m_hi, m_lo} = ref_prod(m_q, m_m);
      m_busy = 0;
    end else begin
      if (wh) m_hi = wd;
      if (wl) m_lo = wd;
    end
    m_done = cap;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, $urandom, $urandom);
  endtask

  function automatic logic [W-1:0] randOp();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    edge_num = 0;
    modelReset();
    clear_n = 1'b0;
    start = 0; flush = 0; wr_hi = 0; wr_lo = 0;
    wr_data = '0; op_q = '0; op_m = '0;
    @(negedge clock);
    compareAll();
    #2 clear_n = 1'b1;

    // Basic product 3 * -2
    applyStimulus(1, 0, 0, 0, '0, 32'd3, 32'hFFFF_FFFE);
    idle(3);
    checkOutput("basic_busy_e3", 64'(busy), 64'd1);
    idle(1);
    checkOutput("basic_done", 64'(done), 64'd1);
    checkOutput("basic_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("basic_lo", 64'(lo), 64'hFFFF_FFFA);
    checkOutput("basic_mq", 64'(mul_q), 64'd3);

    // Extremes, each issued in the done cycle of the previous multiply
    applyStimulus(1, 0, 0, 0, '0, 32'h8000_0000, 32'h8000_0000);
    idle(4);
    checkOutput("min_sq_hi", 64'(hi), 64'h4000_0000);
    checkOutput("min_sq_lo", 64'(lo), 64'h0);
    applyStimulus(1, 0, 0, 0, '0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    idle(1);
    applyStimulus(1, 0, 0, 0, '0, 32'd1, 32'd1);
    idle(2);
    checkOutput("max_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("max_neg_lo", 64'(lo), 64'h8000_0001);
    checkOutput("midwait_mq", 64'(mul_q), 64'h7FFF_FFFF);

    // Back-to-back 5 * 7
    applyStimulus(1, 0, 0, 0, '0, 32'd5, 32'd7);
    idle(3);
    checkOutput("b2b_early", 64'(done), 64'd0);
    idle(1);
    checkOutput("b2b_lo", 64'(lo), 64'd35);
    checkOutput("b2b_hi", 64'(hi), 64'd0);

    // Flush at counter=1, then restart immediately
    applyStimulus(1, 0, 0, 0, '0, 32'd9, 32'd9);
    idle(2);
    applyStimulus(0, 1, 0, 0, '0, '0, '0);
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_lo", 64'(lo), 64'd35);
    applyStimulus(1, 0, 0, 0, '0, 32'd6, 32'd7);
    idle(4);
    checkOutput("after_flush_lo", 64'(lo), 64'd42);

    // Direct writes, and a capture overriding a same-edge write
    applyStimulus(0, 0, 1, 0, 32'hDEAD_BEEF, '0, '0);
    checkOutput("wr_hi", 64'(hi), 64'hDEAD_BEEF);
    applyStimulus(1, 0, 0, 0, '0, 32'd2, 32'd3);
    idle(3);
    applyStimulus(0, 0, 1, 1, 32'h1234, '0, '0);
    checkOutput("cap_wins_lo", 64'(lo), 64'd6);
    checkOutput("cap_wins_hi", 64'(hi), 64'd0);

    // Asynchronous reset mid-operation
    applyStimulus(1, 0, 0, 0, '0, 32'd4, 32'd4);
    idle(1);
    clear_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    #2 clear_n = 1'b1;
    applyStimulus(1, 0, 0, 0, '0, 32'd2, 32'd2);
    idle(3);
    checkOutput("rst_lat_done", 64'(done), 64'd0);
    idle(1);
    checkOutput("rst_lo", 64'(lo), 64'd4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom, randOp(), randOp());
    end
    idle(LATENCY + 1);
    compareAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
